// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter.
// Flattened per-requester slices; the arbiter sits on the slave side.
interface regfile_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        wr;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;

    modport master (
        output req, wr, addr, wdata,
        input  ack, rdata, gnt, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ack, rdata, gnt, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that serialises requester accesses onto a
// single-port register file; three cycles per access (IDLE/ACCESS/ACK).
module regfile_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    regfile_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_we_,
    input  logic [DATA_W-1:0] rf_d_out
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_d_in_q, rf_d_in_d;
    logic              rf_we_q, rf_we_d;

    logic [ADDR_W-1:0] addr_a  [N_REQ];
    logic [DATA_W-1:0] wdata_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_a[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = bus.wdata[i*DATA_W +: DATA_W];
    end

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand_i;
    int               cand;

    // Search starts just after the last winner, so it drops to lowest priority.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        cand   = 0;
        cand_i = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand   = (int'(ptr_q) + k) % N_REQ;
            cand_i = IDX_W'(cand);
            if (!found && bus.req[cand_i]) begin
                found = 1'b1;
                win   = cand_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        ack_d     = '0;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        rf_addr_d = rf_addr_q;
        rf_d_in_d = rf_d_in_q;
        rf_we_d   = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = ACCESS;
                    gidx_d    = win;
                    ptr_d     = win;
                    rf_addr_d = addr_a[win];
                    if (bus.wr[win]) begin
                        rf_d_in_d = wdata_a[win];
                    end
                    rf_we_d   = ~bus.wr[win];
                    gnt_d     = N_REQ'(1) << win;
                    busy_d    = 1'b1;
                end
            end
            ACCESS: begin
                // rf_we_q high marks a read; capture the combinational output.
                if (rf_we_q) begin
                    rdata_d = rf_d_out;
                end
                ack_d   = N_REQ'(1) << gidx_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            gidx_q    <= '0;
            ack_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            rf_addr_q <= '0;
            rf_d_in_q <= '0;
            rf_we_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            ack_q     <= ack_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            rf_addr_q <= rf_addr_d;
            rf_d_in_q <= rf_d_in_d;
            rf_we_q   <= rf_we_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;
    assign rf_addr   = rf_addr_q;
    assign rf_d_in   = rf_d_in_q;
    assign rf_we_    = rf_we_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: vector table, corner sequences and
// random traffic checked against a transaction-level model.
module tb_regfile_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic clr;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [N-1:0]         req_v;
    logic [N-1:0]         wr_v;
    logic [N-1:0][AW-1:0] addr_v;
    logic [N-1:0][DW-1:0] wdata_v;

    assign bus.req   = req_v;
    assign bus.wr    = wr_v;
    assign bus.addr  = addr_v;
    assign bus.wdata = wdata_v;

    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_d_in;
    logic [DW-1:0] rf_d_out;
    logic          rf_we_;

    regfile_arbiter #(
        .N_REQ(N), .IDX_W(2), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rf_addr  (rf_addr),
        .rf_d_in  (rf_d_in),
        .rf_we_   (rf_we_),
        .rf_d_out (rf_d_out)
    );

    // Register file the arbiter drives: combinational read, write at edge.
    logic [DW-1:0] rf_mem [32];
    assign rf_d_out = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (!rf_we_) begin
            rf_mem[rf_addr] <= rf_d_in;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    logic [DW-1:0] m_mem [32];
    int            m_ptr;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_d_in;
    int            ack_cyc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (p + k) % N;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = N - 1;
        m_rdata = '0;
        m_d_in  = '0;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_gnt"}, bus.gnt, 0);
        chk({nm, "_ack"}, bus.ack, 0);
        chk({nm, "_rdata"}, bus.rdata, 0);
        chk({nm, "_addr"}, rf_addr, 0);
        chk({nm, "_din"}, rf_d_in, 0);
        chk({nm, "_we"}, rf_we_, 1);
    endtask

    // One full access starting at an IDLE negedge; nxt is raised in ACK.
    task automatic do_access(input logic [N-1:0] nxt, output int w,
                             output logic [N-1:0] ack_s,
                             output logic [DW-1:0] rd_s,
                             output logic [DW-1:0] din_s);
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        logic          iswr;
        ack_s = '0;
        rd_s  = '0;
        din_s = '0;
        chk("idle_busy", bus.busy, 0);
        chk("idle_gnt", bus.gnt, 0);
        chk("idle_we", rf_we_, 1);
        w = pick(req_v, m_ptr);
        chk("pick_req", w >= 0, 1);
        if (w < 0) return;
        oh = '0;
        oh[w[1:0]] = 1'b1;
        a    = addr_v[w[1:0]];
        iswr = wr_v[w[1:0]];
        if (iswr) m_d_in = wdata_v[w[1:0]];
        @(posedge clk);
        @(negedge clk);
        chk("acc_gnt", bus.gnt, oh);
        chk("acc_busy", bus.busy, 1);
        chk("acc_ack", bus.ack, 0);
        chk("acc_we", rf_we_, !iswr);
        chk("acc_addr", rf_addr, a);
        chk("acc_din", rf_d_in, m_d_in);
        din_s = rf_d_in;
        @(posedge clk);
        @(negedge clk);
        if (iswr) m_mem[a] = wdata_v[w[1:0]];
        else m_rdata = m_mem[a];
        m_ptr = w;
        ack_s = bus.ack;
        rd_s  = bus.rdata;
        ack_cyc = cyc;
        chk("ack_ack", bus.ack, oh);
        chk("ack_rdata", bus.rdata, m_rdata);
        chk("ack_gnt", bus.gnt, oh);
        chk("ack_busy", bus.busy, 1);
        chk("ack_we", rf_we_, 1);
        req_v[w[1:0]] = 1'b0;
        req_v = req_v | nxt;
        @(posedge clk);
        @(negedge clk);
        chk("post_ack", bus.ack, 0);
    endtask

    typedef struct {
        logic [N-1:0]         req;
        logic [N-1:0]         wr;
        logic [N-1:0][AW-1:0] addr;
        logic [N-1:0][DW-1:0] wdata;
        logic [N-1:0]         exp_ack;
        logic [DW-1:0]        exp_rdata;
        logic [DW-1:0]        exp_din;
    } vec_t;

    vec_t tv [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int            w;
        int            last_ack;
        logic [N-1:0]  ack_s;
        logic [DW-1:0] rd_s;
        logic [DW-1:0] din_s;
        logic [N-1:0]  pend;
        int            wait_cnt [N];
        int            rr_exp [5];

        tv[0] = '{req: 4'b0001, wr: 4'b0001,
                  addr: {5'd0, 5'd0, 5'd0, 5'd3},
                  wdata: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                  exp_ack: 4'b0001, exp_rdata: 32'h0,
                  exp_din: 32'hDEADBEEF};
        tv[1] = '{req: 4'b0010, wr: 4'b0000,
                  addr: {5'd0, 5'd0, 5'd3, 5'd0},
                  wdata: {32'h0, 32'h0, 32'h0, 32'h0},
                  exp_ack: 4'b0010, exp_rdata: 32'hDEADBEEF,
                  exp_din: 32'hDEADBEEF};
        tv[2] = '{req: 4'b1000, wr: 4'b1000,
                  addr: {5'd31, 5'd0, 5'd0, 5'd0},
                  wdata: {32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
                  exp_ack: 4'b1000, exp_rdata: 32'hDEADBEEF,
                  exp_din: 32'hFFFFFFFF};
        tv[3] = '{req: 4'b0001, wr: 4'b0000,
                  addr: {5'd0, 5'd0, 5'd0, 5'd31},
                  wdata: {32'h0, 32'h0, 32'h0, 32'h11111111},
                  exp_ack: 4'b0001, exp_rdata: 32'hFFFFFFFF,
                  exp_din: 32'hFFFFFFFF};
        tv[4] = '{req: 4'b0100, wr: 4'b0000,
                  addr: {5'd0, 5'd3, 5'd0, 5'd0},
                  wdata: {32'h0, 32'h0, 32'h0, 32'h0},
                  exp_ack: 4'b0100, exp_rdata: 32'hDEADBEEF,
                  exp_din: 32'hFFFFFFFF};
        tv[5] = '{req: 4'b0101, wr: 4'b0000,
                  addr: {5'd0, 5'd3, 5'd0, 5'd31},
                  wdata: {32'h0, 32'h0, 32'h0, 32'h0},
                  exp_ack: 4'b0001, exp_rdata: 32'hFFFFFFFF,
                  exp_din: 32'hFFFFFFFF};
        tv[6] = '{req: 4'b0101, wr: 4'b0000,
                  addr: {5'd0, 5'd3, 5'd0, 5'd31},
                  wdata: {32'h0, 32'h0, 32'h0, 32'h0},
                  exp_ack: 4'b0100, exp_rdata: 32'hDEADBEEF,
                  exp_din: 32'hFFFFFFFF};
        rr_exp = '{0, 1, 2, 3, 0};

        reset   = 1'b1;
        clr     = 1'b1;
        req_v   = '0;
        wr_v    = '0;
        addr_v  = '0;
        wdata_v = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clr   = 1'b0;
        model_reset();
        check_reset_vals("rst");

        for (int t = 0; t < 7; t++) begin
            req_v   = tv[t].req;
            wr_v    = tv[t].wr;
            addr_v  = tv[t].addr;
            wdata_v = tv[t].wdata;
            do_access('0, w, ack_s, rd_s, din_s);
            chk($sformatf("tbl%0d_ack", t), ack_s, tv[t].exp_ack);
            chk($sformatf("tbl%0d_rdata", t), rd_s, tv[t].exp_rdata);
            chk($sformatf("tbl%0d_din", t), din_s, tv[t].exp_din);
        end

        // All four read and keep requesting: strict rotation, 3-cycle spacing.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        req_v  = 4'b1111;
        wr_v   = 4'b0000;
        addr_v = {5'd3, 5'd2, 5'd1, 5'd0};
        last_ack = 0;
        for (int j = 0; j < 5; j++) begin
            do_access(4'b1111, w, ack_s, rd_s, din_s);
            chk($sformatf("rr%0d_winner", j), w, rr_exp[j]);
            if (j > 0) chk($sformatf("rr%0d_gap", j), ack_cyc - last_ack, 3);
            last_ack = ack_cyc;
        end

        // Reset lands on the ACCESS edge of a write: no ack, write commits.
        req_v      = 4'b0100;
        wr_v       = 4'b0100;
        addr_v[2]  = 5'd7;
        wdata_v[2] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        chk("rstacc_we", rf_we_, 0);
        chk("rstacc_addr", rf_addr, 7);
        reset = 1'b1;
        req_v = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        m_mem[7] = 32'h12345678;
        check_reset_vals("rstacc");
        chk("rstacc_mem", rf_mem[7], 32'h12345678);
        req_v     = 4'b0010;
        wr_v      = 4'b0000;
        addr_v[1] = 5'd7;
        do_access('0, w, ack_s, rd_s, din_s);
        chk("rstacc_next_winner", w, 1);
        chk("rstacc_next_rdata", rd_s, 32'h12345678);

        // Request raised during another access's ACK waits for next IDLE.
        req_v     = 4'b0001;
        addr_v[0] = 5'd7;
        addr_v[3] = 5'd31;
        do_access(4'b1000, w, ack_s, rd_s, din_s);
        chk("ackreq_first", w, 0);
        do_access('0, w, ack_s, rd_s, din_s);
        chk("ackreq_second", w, 3);
        chk("ackreq_rdata", rd_s, 32'hFFFFFFFF);

        // Reset during ACK drops the pending ack on that edge.
        req_v = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstack_ack_before", bus.ack, 4'b0010);
        reset = 1'b1;
        req_v = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_vals("rstack");

        // Random traffic against the transaction model.
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    wr_v[i]    = 1'($urandom_range(0, 1));
                    addr_v[i]  = 5'($urandom_range(0, 31));
                    wdata_v[i] = $urandom;
                    req_v[i]   = 1'b1;
                    wait_cnt[i] = 0;
                end
            end
            if (req_v == '0) begin
                @(posedge clk);
                @(negedge clk);
                chk("rnd_idle_busy", bus.busy, 0);
            end else begin
                pend = req_v;
                do_access('0, w, ack_s, rd_s, din_s);
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && i != w) begin
                        wait_cnt[i]++;
                        chk("rnd_starve", wait_cnt[i] > N - 1, 0);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
